demux_2ch_splitter: RTL and testbench
=====================================

// Module: demux_2ch_splitter
// PURPOSE
// - Receive end of the 2:1 byte multiplexer link: splits one interleaved byte stream (lane 0 slot, lane 1 slot, ...) back into two 8-bit lanes, each with its own valid.
// - Sits downstream of the mux on the same clock. Presents each lane pair together at half the input rate.
// - Keeps saturating per-lane counts of valid bytes received, for bench-side checking.
// PARAMETERS
// DATA_W   8    width of the stream byte and of each lane
// CNT_W    16   width of each per-lane valid-byte counter
// PORTS
// clk          in   1       single clock; all logic on posedge
// reset        in   1       asynchronous, active-low reset
// data_in      in   DATA_W  interleaved stream byte; even slot = lane 0, odd slot = lane 1
// valid_in     in   1       data_in carries a valid byte for the current slot
// data_out_0   out  DATA_W  lane 0 byte, held for one pair period (2 cycles)
// data_out_1   out  DATA_W  lane 1 byte, held for one pair period (2 cycles)
// valid_out_0  out  1       data_out_0 is valid for this pair period
// valid_out_1  out  1       data_out_1 is valid for this pair period
// pair_strobe  out  1       1-cycle pulse; high in the first cycle of each new output pair
// cnt_0        out  CNT_W   number of valid lane 0 bytes since reset; saturates
// cnt_1        out  CNT_W   number of valid lane 1 bytes since reset; saturates
// BEHAVIOUR
// - Reset (reset=0, asynchronous):
//   - All outputs go to 0: data_out_*, valid_out_*, pair_strobe, cnt_*.
//   - Capture registers are cleared. The FSM goes to SLOT0.
// - FSM with two states, advancing on every posedge, independent of valid_in:
//   - SLOT0 -> SLOT1 -> SLOT0 ...
//   - The first posedge after reset release samples in SLOT0 (lane 0).
// - SLOT0 edge: cap0_data <= data_in; cap0_valid <= valid_in. Outputs are unchanged. pair_strobe <= 0.
// - SLOT1 edge: the output pair updates.
//   - valid_out_0 <= cap0_valid; valid_out_1 <= valid_in.
//   - data_out_0 <= cap0_data only if cap0_valid; otherwise it holds its previous value.
//   - data_out_1 <= data_in only if valid_in; otherwise it holds its previous value.
//   - pair_strobe <= 1.
// - Latency:
//   - Lane 0 byte sampled at edge N appears after edge N+1.
//   - Lane 1 byte sampled at edge N+1 appears after that same edge.
//   - Both stay stable for exactly 2 cycles.
// - Counters:
//   - cnt_0 += 1 at each SLOT0 edge with valid_in=1.
//   - cnt_1 += 1 at each SLOT1 edge with valid_in=1.
//   - Both saturate at 2^CNT_W-1 with no wrap.
//   - Counts update at the sampling edge, not at the output edge.
// - Simultaneous events: none possible; each edge belongs to exactly one slot.
// - An invalid slot never disturbs the other lane.
// - Reset mid-pair: a half-captured lane 0 byte is discarded. No pair_strobe is issued for it.
// - No back-pressure: the downstream must accept each pair within its 2-cycle window.
// TESTING
// - Reset held 3 cycles with data_in=8'hAA, valid_in=1 -> all outputs 0; cnt_0=cnt_1=0 throughout.
// - Release reset; drive 8'h11/v1 then 8'hFF/v1 -> after 2nd edge: data_out_0=8'h11, data_out_1=8'hFF, valid_out_0=1, valid_out_1=1, pair_strobe high 1 cycle; cnt_0=1, cnt_1=1.
// - Then 8'h13/v1, 8'hFD/v0 -> data_out_0=8'h13, valid_out_0=1; data_out_1 stays 8'hFF with valid_out_1=0; cnt_1 unchanged.
// - 16 slots of valid_in=0 -> valid_out_* stay 0, data_out_* hold their last values, pair_strobe still pulses every 2 cycles, counters frozen.
// - Assert reset after a SLOT0 capture of 8'h1D/v1 -> outputs 0 immediately; after release, 8'h22/v1 then 8'hEE/v1 -> pair 8'h22/8'hEE, with no trace of 8'h1D.
// - CNT_W=2 build with 5 valid lane 0 bytes -> cnt_0 saturates at 3; cnt_1 counts its own valid bytes independently.

Source files
------------

// File: rtl/demux_2ch_splitter.sv
// Receive side of the 2:1 byte link: de-interleaves one byte stream into two lanes
// presented together once per two-cycle pair period, with saturating valid counts.
module demux_2ch_splitter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_0,
    output logic              valid_out_1,
    output logic              pair_strobe,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1
);

    typedef enum logic {
        SLOT0 = 1'b0,
        SLOT1 = 1'b1
    } slot_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_e             state_q, state_d;
    logic [DATA_W-1:0] cap0Data_q, cap0Data_d;
    logic              cap0Valid_q, cap0Valid_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SLOT0;
            cap0Data_q  <= '0;
            cap0Valid_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            strobe_q    <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            cap0Data_q  <= cap0Data_d;
            cap0Valid_q <= cap0Valid_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            strobe_q    <= strobe_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    // Slot parity alone decides the work of each edge; valid_in only gates what is kept.
    always_comb begin
        state_d     = state_q;
        cap0Data_d  = cap0Data_q;
        cap0Valid_d = cap0Valid_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        strobe_d    = 1'b0;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;

        case (state_q)
            SLOT0: begin
                state_d     = SLOT1;
                cap0Data_d  = data_in;
                cap0Valid_d = valid_in;
                if (valid_in && (cnt0_q != CNT_MAX)) begin
                    cnt0_d = cnt0_q + CNT_ONE;
                end
            end
            SLOT1: begin
                state_d  = SLOT0;
                strobe_d = 1'b1;
                valid0_d = cap0Valid_q;
                valid1_d = valid_in;
                if (cap0Valid_q) begin
                    data0_d = cap0Data_q;
                end
                if (valid_in) begin
                    data1_d = data_in;
                end
                if (valid_in && (cnt1_q != CNT_MAX)) begin
                    cnt1_d = cnt1_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SLOT0;
            end
        endcase
    end

    assign data_out_0  = data0_q;
    assign data_out_1  = data1_q;
    assign valid_out_0 = valid0_q;
    assign valid_out_1 = valid1_q;
    assign pair_strobe = strobe_q;
    assign cnt_0       = cnt0_q;
    assign cnt_1       = cnt1_q;

endmodule

// File: tb/tb_demux_2ch_splitter.sv
// Bench for demux_2ch_splitter: directed vector table, reset corner sequences,
// a narrow-counter saturation build, and random traffic against a lane model.
module tb_demux_2ch_splitter;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;

    logic [7:0]  do0, do1;
    logic        vo0, vo1, stb;
    logic [15:0] cnt0, cnt1;

    logic [7:0]  sDo0, sDo1;
    logic        sVo0, sVo1, sStb;
    logic [1:0]  sCnt0, sCnt1;

    int checks = 0;
    int errors = 0;

    demux_2ch_splitter #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out_0(do0), .data_out_1(do1), .valid_out_0(vo0), .valid_out_1(vo1),
        .pair_strobe(stb), .cnt_0(cnt0), .cnt_1(cnt1)
    );

    demux_2ch_splitter #(.DATA_W(8), .CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out_0(sDo0), .data_out_1(sDo1), .valid_out_0(sVo0), .valid_out_1(sVo1),
        .pair_strobe(sStb), .cnt_0(sCnt0), .cnt_1(sCnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] eDo0;
        logic [7:0] eDo1;
        logic       eVo0;
        logic       eVo1;
        logic       eStb;
        int         eCnt0;
        int         eCnt1;
    } vec_t;

    vec_t vecs[20];

    // Behavioural view: edges since release alternate lanes; a lane 0 byte waits
    // for its partner, then both appear together.
    int         mEdge;
    logic [7:0] mPendD;
    logic       mPendV;
    logic [7:0] mDo0, mDo1;
    logic       mVo0, mVo1, mStb;
    int         mRaw0, mRaw1;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] eDo0, input logic [7:0] eDo1,
                               input logic eVo0, input logic eVo1, input logic eStb,
                               input int eCnt0, input int eCnt1);
        checkVal({tag, ".data_out_0"}, int'(do0), int'(eDo0));
        checkVal({tag, ".data_out_1"}, int'(do1), int'(eDo1));
        checkVal({tag, ".valid_out_0"}, int'(vo0), int'(eVo0));
        checkVal({tag, ".valid_out_1"}, int'(vo1), int'(eVo1));
        checkVal({tag, ".pair_strobe"}, int'(stb), int'(eStb));
        checkVal({tag, ".cnt_0"}, int'(cnt0), eCnt0);
        checkVal({tag, ".cnt_1"}, int'(cnt1), eCnt1);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic v);
        data_in  = d;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mEdge = 0; mPendD = '0; mPendV = 1'b0;
        mDo0 = '0; mDo1 = '0; mVo0 = 1'b0; mVo1 = 1'b0; mStb = 1'b0;
        mRaw0 = 0; mRaw1 = 0;
    endtask

    task automatic modelStep(input logic [7:0] d, input logic v);
        if (mEdge % 2 == 0) begin
            mPendD = d; mPendV = v; mStb = 1'b0;
            mRaw0 += int'(v);
        end else begin
            mVo0 = mPendV; mVo1 = v; mStb = 1'b1;
            if (mPendV) mDo0 = mPendD;
            if (v) mDo1 = d;
            mRaw1 += int'(v);
        end
        mEdge++;
    endtask

    function automatic int sat(input int raw, input int maxVal);
        return (raw > maxVal) ? maxVal : raw;
    endfunction

    task automatic doReset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; data_in = 8'hAA; valid_in = 1'b1;

        // Reset held with live traffic: every output must stay zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        end

        vecs[0] = '{8'h11, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 8'h11, 8'hFF, 1'b1, 1'b1, 1'b1, 1, 1};
        vecs[2] = '{8'h13, 1'b1, 8'h11, 8'hFF, 1'b1, 1'b1, 1'b0, 2, 1};
        vecs[3] = '{8'hFD, 1'b0, 8'h13, 8'hFF, 1'b1, 1'b0, 1'b1, 2, 1};
        for (int i = 4; i < 20; i++) begin
            vecs[i].d     = 8'(8'h40 + i);
            vecs[i].v     = 1'b0;
            vecs[i].eDo0  = 8'h13;
            vecs[i].eDo1  = 8'hFF;
            vecs[i].eVo0  = (i == 4);
            vecs[i].eVo1  = 1'b0;
            vecs[i].eStb  = (i % 2 == 1);
            vecs[i].eCnt0 = 2;
            vecs[i].eCnt1 = 1;
        end

        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].d, vecs[i].v);
            checkOutput($sformatf("vec%0d", i), vecs[i].eDo0, vecs[i].eDo1, vecs[i].eVo0,
                        vecs[i].eVo1, vecs[i].eStb, vecs[i].eCnt0, vecs[i].eCnt1);
        end

        // Reset after a half-captured lane 0 byte: it must vanish without a strobe.
        applyStimulus(8'h1D, 1'b1);
        checkVal("pre_mid_reset.cnt_0", int'(cnt0), 3);
        #2 reset = 1'b0;
        #1 checkOutput("async_clear", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(8'h22, 1'b1);
        checkOutput("after_rst_slot0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0);
        applyStimulus(8'hEE, 1'b1);
        checkOutput("after_rst_pair", 8'h22, 8'hEE, 1'b1, 1'b1, 1'b1, 1, 1);

        // Saturation: five valid lane 0 bytes, only two valid lane 1 bytes.
        doReset(2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'h30 + i), 1'b1);
            applyStimulus(8'(8'hC0 + i), (i < 2));
        end
        checkVal("sat.small_cnt_0", int'(sCnt0), 3);
        checkVal("sat.small_cnt_1", int'(sCnt1), 2);
        checkVal("sat.big_cnt_0", int'(cnt0), 5);
        checkVal("sat.big_cnt_1", int'(cnt1), 2);
        checkVal("sat.small_data_out_0", int'(sDo0), 8'h34);
        checkVal("sat.small_data_out_1", int'(sDo1), 8'hC1);

        // Random traffic compared with the lane model, both counter widths.
        doReset(2);
        modelReset();
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rd;
            logic       rv;
            rd = 8'($urandom_range(0, 255));
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(rd, rv);
            modelStep(rd, rv);
            checkOutput($sformatf("rand%0d", i), mDo0, mDo1, mVo0, mVo1, mStb,
                        sat(mRaw0, 65535), sat(mRaw1, 65535));
            checkVal($sformatf("rand%0d.small_cnt_0", i), int'(sCnt0), sat(mRaw0, 3));
            checkVal($sformatf("rand%0d.small_cnt_1", i), int'(sCnt1), sat(mRaw1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
